// File: rtl/cordic_rotate.sv
// Pipelined CORDIC rotator: turns four polygon vertices by one shared residual
// angle. Pixel sideband travels alongside the data through the same register depth.
module cordic_rotate #(
    parameter int ITER = 8,
    parameter int FRAC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [18:0] v1_x,
    input  logic signed [18:0] v1_y,
    input  logic signed [18:0] v2_x,
    input  logic signed [18:0] v2_y,
    input  logic signed [18:0] v3_x,
    input  logic signed [18:0] v3_y,
    input  logic signed [18:0] v4_x,
    input  logic signed [18:0] v4_y,
    input  logic signed [8:0]  angle_cordic,
    input  logic               enable_cordic,
    input  logic               form,
    input  logic [8:0]         st2_color,
    input  logic [9:0]         st2_pixel_x,
    input  logic [9:0]         st2_pixel_y,
    input  logic               st2_bubble,
    input  logic [8:0]         ref_point_x,
    input  logic [8:0]         ref_point_y,
    output logic signed [18:0] rot_v1_x,
    output logic signed [18:0] rot_v1_y,
    output logic signed [18:0] rot_v2_x,
    output logic signed [18:0] rot_v2_y,
    output logic signed [18:0] rot_v3_x,
    output logic signed [18:0] rot_v3_y,
    output logic signed [18:0] rot_v4_x,
    output logic signed [18:0] rot_v4_y,
    output logic               out_form,
    output logic [8:0]         out_st2_color,
    output logic [9:0]         out_st2_pixel_x,
    output logic [9:0]         out_st2_pixel_y,
    output logic               out_st2_bubble,
    output logic [8:0]         out_ref_point_x,
    output logic [8:0]         out_ref_point_y
);
    // Two guard bits above the 19-bit coordinate cover CORDIC growth (~1.65x).
    localparam int W   = 19 + FRAC + 2;
    localparam int ZW  = 16;
    localparam int SBW = 49;
    localparam logic signed [W-1:0] HALF = W'(1) <<< (FRAC - 1);

    // atan(2^-i) with 90 degrees = 16384.
    function automatic logic signed [ZW-1:0] atan_lut(input int i);
        case (i)
            0:       return 16'sd8192;
            1:       return 16'sd4836;
            2:       return 16'sd2555;
            3:       return 16'sd1297;
            4:       return 16'sd651;
            5:       return 16'sd326;
            6:       return 16'sd163;
            7:       return 16'sd81;
            8:       return 16'sd41;
            9:       return 16'sd20;
            default: return '0;
        endcase
    endfunction

    // Matches the ~1.647 CORDIC gain so bypassed items leave with rotate-mode magnitude.
    function automatic logic signed [W-1:0] gain_f(input logic signed [W-1:0] v);
        return v + (v >>> 1) + (v >>> 3) + (v >>> 6) + (v >>> 7);
    endfunction

    // Round half-up, drop the fractional bits, keep the low 19 bits (range is guaranteed).
    function automatic logic signed [18:0] round_f(input logic signed [W-1:0] v);
        logic signed [W-1:0] r;
        r = (v + HALF) >>> FRAC;
        return r[18:0];
    endfunction

    logic signed [18:0] vin_w [8];
    logic [SBW-1:0]     sb_in_w;

    // Gather the vertex ports into an array: index 2k is x, 2k+1 is y of vertex k+1.
    always_comb begin
        vin_w[0] = v1_x;
        vin_w[1] = v1_y;
        vin_w[2] = v2_x;
        vin_w[3] = v2_y;
        vin_w[4] = v3_x;
        vin_w[5] = v3_y;
        vin_w[6] = v4_x;
        vin_w[7] = v4_y;
        sb_in_w  = {form, st2_color, st2_pixel_x, st2_pixel_y, st2_bubble,
                    ref_point_x, ref_point_y};
    end

    for (genvar s = 0; s < ITER; s++) begin : g_stage
        logic signed [W-1:0]  xy_in [8];
        logic signed [ZW-1:0] z_in;
        logic                 en_in;
        logic [SBW-1:0]       sb_in;
        logic signed [W-1:0]  xy_d [8];
        logic signed [ZW-1:0] z_d;
        logic signed [W-1:0]  xy_q [8];
        logic signed [ZW-1:0] z_q;
        logic                 en_q;
        logic [SBW-1:0]       sb_q;

        if (s == 0) begin : g_entry
            // Entry: widen coordinates and scale the angle into z units.
            always_comb begin
                for (int k = 0; k < 8; k++) xy_in[k] = W'(vin_w[k]) <<< FRAC;
                z_in  = ZW'(angle_cordic) <<< 7;
                en_in = enable_cordic;
                sb_in = sb_in_w;
            end
        end else begin : g_chain
            // Chain from the previous micro-rotation register.
            always_comb begin
                for (int k = 0; k < 8; k++) xy_in[k] = g_stage[s-1].xy_q[k];
                z_in  = g_stage[s-1].z_q;
                en_in = g_stage[s-1].en_q;
                sb_in = g_stage[s-1].sb_q;
            end
        end

        // Micro-rotation s: one direction decision from the shared z steers all four vertices.
        always_comb begin
            for (int k = 0; k < 8; k++) xy_d[k] = xy_in[k];
            z_d = z_in;
            if (en_in) begin
                for (int k = 0; k < 4; k++) begin
                    if (!z_in[ZW-1]) begin
                        xy_d[2*k]   = xy_in[2*k]   - (xy_in[2*k+1] >>> s);
                        xy_d[2*k+1] = xy_in[2*k+1] + (xy_in[2*k]   >>> s);
                    end else begin
                        xy_d[2*k]   = xy_in[2*k]   + (xy_in[2*k+1] >>> s);
                        xy_d[2*k+1] = xy_in[2*k+1] - (xy_in[2*k]   >>> s);
                    end
                end
                z_d = z_in[ZW-1] ? z_in + atan_lut(s) : z_in - atan_lut(s);
            end
        end

        // Stage register; reset flushes every in-flight item.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < 8; k++) xy_q[k] <= '0;
                z_q  <= '0;
                en_q <= 1'b0;
                sb_q <= '0;
            end else begin
                for (int k = 0; k < 8; k++) xy_q[k] <= xy_d[k];
                z_q  <= z_d;
                en_q <= en_in;
                sb_q <= sb_in;
            end
        end
    end

    logic signed [18:0] out_d [8];
    logic signed [18:0] out_q [8];
    logic [SBW-1:0]     sb_out_q;

    // Output stage: gain only on bypassed items, then rounding back to coordinate units.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            out_d[k] = g_stage[ITER-1].en_q ? round_f(g_stage[ITER-1].xy_q[k])
                                            : round_f(gain_f(g_stage[ITER-1].xy_q[k]));
        end
    end

    // Output register, the last of the ITER+1 pipeline levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) out_q[k] <= '0;
            sb_out_q <= '0;
        end else begin
            for (int k = 0; k < 8; k++) out_q[k] <= out_d[k];
            sb_out_q <= g_stage[ITER-1].sb_q;
        end
    end

    assign rot_v1_x = out_q[0];
    assign rot_v1_y = out_q[1];
    assign rot_v2_x = out_q[2];
    assign rot_v2_y = out_q[3];
    assign rot_v3_x = out_q[4];
    assign rot_v3_y = out_q[5];
    assign rot_v4_x = out_q[6];
    assign rot_v4_y = out_q[7];
    assign {out_form, out_st2_color, out_st2_pixel_x, out_st2_pixel_y, out_st2_bubble,
            out_ref_point_x, out_ref_point_y} = sb_out_q;

endmodule

// File: tb/tb_cordic_rotate.sv
// Bench for cordic_rotate: directed steps plus a random stream, checked against a
// real-arithmetic rotation model through a fixed-latency scoreboard queue.
module tb_cordic_rotate;
    localparam int  ITER = 8;
    localparam int  FRAC = 4;
    localparam real PI   = 3.14159265358979;

    typedef struct packed {
        logic [7:0][18:0] v;
        logic [7:0]       tol;
        logic [48:0]      sb;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_s;
    logic signed [18:0] vin [8];
    logic signed [8:0]  ang_s;
    logic               en_s;
    logic               form_s;
    logic [8:0]         color_s;
    logic [9:0]         px_s;
    logic [9:0]         py_s;
    logic               bub_s;
    logic [8:0]         rx_s;
    logic [8:0]         ry_s;

    logic signed [18:0] vout [8];
    logic               o_form;
    logic [8:0]         o_color;
    logic [9:0]         o_px;
    logic [9:0]         o_py;
    logic               o_bub;
    logic [8:0]         o_rx;
    logic [8:0]         o_ry;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    real  kgain;

    always #5 clk = ~clk;

    cordic_rotate #(.ITER(ITER), .FRAC(FRAC)) dut (
        .clk(clk), .reset(rst_s),
        .v1_x(vin[0]), .v1_y(vin[1]), .v2_x(vin[2]), .v2_y(vin[3]),
        .v3_x(vin[4]), .v3_y(vin[5]), .v4_x(vin[6]), .v4_y(vin[7]),
        .angle_cordic(ang_s), .enable_cordic(en_s),
        .form(form_s), .st2_color(color_s), .st2_pixel_x(px_s), .st2_pixel_y(py_s),
        .st2_bubble(bub_s), .ref_point_x(rx_s), .ref_point_y(ry_s),
        .rot_v1_x(vout[0]), .rot_v1_y(vout[1]), .rot_v2_x(vout[2]), .rot_v2_y(vout[3]),
        .rot_v3_x(vout[4]), .rot_v3_y(vout[5]), .rot_v4_x(vout[6]), .rot_v4_y(vout[7]),
        .out_form(o_form), .out_st2_color(o_color), .out_st2_pixel_x(o_px),
        .out_st2_pixel_y(o_py), .out_st2_bubble(o_bub),
        .out_ref_point_x(o_rx), .out_ref_point_y(o_ry)
    );

    function automatic logic signed [18:0] rnd_real(input real r);
        return 19'($rtoi($floor(r + 0.5)));
    endfunction

    // Bypass: gain 1 + 1/2 + 1/8 + 1/64 + 1/128 on the fixed-point value, round half-up.
    function automatic logic signed [18:0] bypass_ref(input logic signed [18:0] v);
        int iv;
        int g;
        iv = int'(v) * (1 << FRAC);
        g  = iv + (iv >>> 1) + (iv >>> 3) + (iv >>> 6) + (iv >>> 7);
        return 19'((g + (1 << (FRAC - 1))) >>> FRAC);
    endfunction

    function automatic exp_t model();
        exp_t e;
        real  th, c, s, x, y;
        e    = '0;
        e.sb = {form_s, color_s, px_s, py_s, bub_s, rx_s, ry_s};
        th   = real'(ang_s) * 90.0 / 128.0 * PI / 180.0;
        c    = $cos(th);
        s    = $sin(th);
        for (int k = 0; k < 4; k++) begin
            if (en_s) begin
                x = real'(vin[2*k]);
                y = real'(vin[2*k+1]);
                e.v[2*k]   = rnd_real(kgain * (x * c - y * s));
                e.v[2*k+1] = rnd_real(kgain * (x * s + y * c));
                e.tol[2*k]   = (vin[2*k] != 0 || vin[2*k+1] != 0);
                e.tol[2*k+1] = (vin[2*k] != 0 || vin[2*k+1] != 0);
            end else begin
                e.v[2*k]   = bypass_ref(vin[2*k]);
                e.v[2*k+1] = bypass_ref(vin[2*k+1]);
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v, input int tol);
        n_tests++;
        if (tol == 0) begin
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
            end
        end else begin
            assert (obs >= exp_v - tol && obs <= exp_v + tol) else begin
                n_fail++;
                $error("FAIL %s: observed %0d, expected %0d +/-%0d", tag, obs, exp_v, tol);
            end
        end
    endtask

    // One clock: enqueue the expectation for the item on the pins, then check the output.
    task automatic cycle(input string tag);
        exp_t e;
        logic [48:0] osb;
        if (rst_s) begin
            exp_q.delete();
            for (int i = 0; i <= ITER; i++) exp_q.push_back('0);
        end else begin
            exp_q.push_back(model());
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s v%0d_%s", tag, k / 2 + 1, (k % 2) ? "y" : "x"),
                32'(vout[k]), 32'($signed(e.v[k])), int'(e.tol[k]));
        end
        osb = {o_form, o_color, o_px, o_py, o_bub, o_rx, o_ry};
        n_tests++;
        assert (osb === e.sb) else begin
            n_fail++;
            $error("FAIL %s sideband: observed %h, expected %h", tag, osb, e.sb);
        end
    endtask

    task automatic set_zero();
        for (int k = 0; k < 8; k++) vin[k] = '0;
        ang_s = '0; en_s = 1'b0; form_s = 1'b0; color_s = '0; px_s = '0; py_s = '0;
        bub_s = 1'b0; rx_s = '0; ry_s = '0;
    endtask

    task automatic set_random(input int idx);
        for (int k = 0; k < 8; k++) vin[k] = 19'(int'($urandom_range(30)) - 15);
        ang_s   = 9'(int'($urandom_range(255)) - 128);
        en_s    = 1'($urandom_range(1));
        form_s  = 1'($urandom_range(1));
        color_s = 9'($urandom_range(511));
        px_s    = 10'(idx);
        py_s    = 10'($urandom_range(1023));
        bub_s   = 1'(idx % 2);
        rx_s    = 9'($urandom_range(511));
        ry_s    = 9'($urandom_range(511));
    endtask

    initial begin
        real p;
        kgain = 1.0;
        p = 1.0;
        for (int i = 0; i < ITER; i++) begin
            kgain = kgain * $sqrt(1.0 + p);
            p = p / 4.0;
        end

        // Reset held three cycles with busy inputs.
        rst_s = 1'b1;
        set_random(7);
        for (int i = 0; i < 3; i++) cycle("reset");
        rst_s = 1'b0;

        // Bypass: v1=(38,-38), v3=(-38,38) -> (63,-63), (-63,63).
        set_zero();
        vin[0] = 19'sd38; vin[1] = -19'sd38; vin[4] = -19'sd38; vin[5] = 19'sd38;
        px_s = 10'd1;
        cycle("bypass");

        // +45 degrees on v1=(38,0).
        set_zero();
        en_s = 1'b1; ang_s = 9'sd64; vin[0] = 19'sd38; px_s = 10'd2;
        cycle("rot+45");

        // -90 degrees: v2=(0,38) and v4=(38,0).
        set_zero();
        en_s = 1'b1; ang_s = -9'sd128; vin[3] = 19'sd38; vin[6] = 19'sd38; px_s = 10'd3;
        cycle("rot-90");

        // Back-to-back random stream with mixed modes.
        for (int i = 0; i < 20; i++) begin
            set_random(i);
            cycle("stream");
        end

        // Stream with a single reset cycle at item 5.
        for (int i = 0; i < 10; i++) begin
            rst_s = (i == 5);
            set_random(100 + i);
            cycle("midreset");
        end
        rst_s = 1'b0;

        // Drain the pipeline with idle items.
        set_zero();
        for (int i = 0; i <= ITER; i++) cycle("drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_rotate.md
Name: cordic_rotate

Overview:
- Pipelined CORDIC rotation stage, directly downstream of the vertex pre-rotation stage.
- Consumes the four pre-rotated, gain-prescaled polygon vertices plus the residual angle in [-90°, +89.3°].
- Rotates all four vertices by that angle in parallel and emits them, with all pixel sideband delayed to match.
- Accepts one new item every cycle; fixed latency; no stall.

Parameters:
- ITER, 8: number of micro-rotation stages. Legal range 4..10.
- FRAC, 4: extra fractional bits carried internally on x/y.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, v4_x, v4_y  in  19 each  signed prescaled vertex coordinates.
- angle_cordic  in  9  signed residual angle; 1 LSB = 90/128 degrees.
- enable_cordic  in  1  1 = rotate; 0 = bypass rotation.
- form, st2_color[9], st2_pixel_x[10], st2_pixel_y[10], st2_bubble, ref_point_x[9], ref_point_y[9]  in  sideband.
- rot_v1_x .. rot_v4_y  out  19 each  signed rotated vertices.
- out_form, out_st2_color, out_st2_pixel_x, out_st2_pixel_y, out_st2_bubble, out_ref_point_x, out_ref_point_y  out  same widths as inputs  delayed sideband.

Behaviour:
- Reset: all pipeline registers clear synchronously while reset=1. Every output reads 0 the cycle after reset is sampled and stays 0 until valid data propagates through.
- Reset mid-stream discards all in-flight items. No partial results emerge.
- Latency: exactly ITER+1 cycles, input sample edge to output valid. Throughput is 1 item per cycle.
- Sideband and st2_bubble pass through the same ITER+1 register depth, untouched.
- Processing is unconditional: bubbles flow through the datapath like any other item.
- Entry: each x/y is sign-extended to 19+FRAC+2 bits and shifted left by FRAC. z = angle_cordic sign-extended to 16 bits, shifted left by 7.
- Stage i (0..ITER-1):
  - d = +1 if z >= 0, else -1.
  - x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*A[i].
  - The same d drives all four vertices; one shared z per item.
  - A[0..9] = 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20 (atan(2^-i) in z units, 90° = 16384).
- Rotation sense: positive angle rotates counter-clockwise.
- No gain compensation in rotate mode; the upstream prescale already divides by ~1.647.
- Bypass (enable_cordic=0 captured with the item): every stage passes x/y/z unchanged.
  - The output stage applies gain G(v) = v + v>>>1 + v>>>3 + v>>>6 + v>>>7 on the internal value.
  - Result: bypass and rotate paths produce the same magnitude.
  - The enable bit travels with its item; consecutive items may mix modes freely.
- Output stage: round half-up, (v + 2^(FRAC-1)) >>> FRAC, then truncate to 19 bits.
- No saturation. Input range is guaranteed |v| < 2^16, so no overflow occurs.
- angle_cordic = -128 (exactly -90°) must converge within ITER=8; residual error ≤ 1 LSB per coordinate.

Test Plan:
- Reset: drive nonzero inputs with reset=1 for 3 cycles -> all outputs 0. Deassert; outputs stay 0 for ITER+1 cycles, then show the first post-reset item.
- Bypass: enable_cordic=0, v1=(38,-38), v3=(-38,38) -> after 9 cycles rot_v1=(63,-63), rot_v3=(-63,63) exactly.
- +45°: enable=1, angle=64, v1=(38,0) -> rot_v1=(44,44) ±1. Other vertices set to 0 -> stay (0,0).
- -90°: enable=1, angle=-128, v2=(0,38) -> rot_v2=(63,0) ±1. Same item with v4=(38,0) -> rot_v4=(0,-63) ±1.
- Streaming: 20 back-to-back items with random angles, random enable, alternating st2_bubble, incrementing pixel_x -> output k matches a reference model of input k-(ITER+1) within ±1. Sideband matches exactly; no gaps.
- Mid-stream reset: assert reset for 1 cycle at item 5 of a stream -> no item issued before the reset ever appears at the outputs. Outputs are 0 until the first post-reset item arrives ITER+1 cycles later.
